// File: rtl/nems_cfg_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : nems_cfg_ctrl
// Description : Sequencer for the NEMS relay crossbar configuration grid of a
//               CLB tile. Drives rows first, pulses one column (or all columns
//               for an erase), then holds the rows, and tracks which columns
//               have been written since the last reset/erase.
// Revision    : 1.0 - initial release
// ============================================================================
module nems_cfg_ctrl #(
    parameter int NROWS     = 30,
    parameter int NCOLS     = 29,
    parameter int COLW      = 5,
    parameter int SETUP_CYC = 4,
    parameter int PULSE_CYC = 16,
    parameter int HOLD_CYC  = 4,
    parameter int CNTW      = 8
) (
    input  logic             cfg_clk,
    input  logic             cfg_rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic             in_erase,
    input  logic [COLW-1:0]  in_col,
    input  logic [NROWS-1:0] in_rows,
    output logic [NROWS-1:0] cfgrows,
    output logic [NCOLS-1:0] cfgcols,
    output logic             busy,
    output logic             col_err,
    output logic [NCOLS-1:0] col_written,
    output logic             all_written
);

    localparam logic [1:0] c_st_idle  = 2'd0;
    localparam logic [1:0] c_st_setup = 2'd1;
    localparam logic [1:0] c_st_pulse = 2'd2;
    localparam logic [1:0] c_st_hold  = 2'd3;

    // Phase counters are loaded with (count-1) and run down to zero.
    localparam logic [CNTW-1:0]  c_setup_last = CNTW'(SETUP_CYC - 1);
    localparam logic [CNTW-1:0]  c_pulse_last = CNTW'(PULSE_CYC - 1);
    localparam logic [CNTW-1:0]  c_hold_last  = CNTW'(HOLD_CYC - 1);
    localparam logic [CNTW-1:0]  c_cnt_one    = CNTW'(1);
    localparam logic [COLW:0]    c_ncols      = (COLW + 1)'(NCOLS);
    localparam logic [NCOLS-1:0] c_col_one    = NCOLS'(1);

    logic [1:0]       r_state;
    logic [CNTW-1:0]  r_cnt;
    logic             r_erase;
    // Column mask used during PULSE: one-hot for a write, all ones for erase.
    logic [NCOLS-1:0] r_col_mask;
    logic [NROWS-1:0] r_cfgrows;
    logic [NCOLS-1:0] r_cfgcols;
    logic             r_col_err;
    logic [NCOLS-1:0] r_col_written;

    logic             w_accept;
    logic             w_col_bad;
    logic [NCOLS-1:0] w_col_oh;

    assign w_accept  = in_valid && (r_state == c_st_idle);
    assign w_col_bad = !in_erase && ({1'b0, in_col} >= c_ncols);
    assign w_col_oh  = c_col_one << in_col;

    assign in_ready    = (r_state == c_st_idle);
    assign busy        = (r_state != c_st_idle);
    assign cfgrows     = r_cfgrows;
    assign cfgcols     = r_cfgcols;
    assign col_err     = r_col_err;
    assign col_written = r_col_written;
    assign all_written = &r_col_written;

    // Phase sequencer: command latch, phase timing and registered grid drive.
    always_ff @(posedge cfg_clk or posedge cfg_rst) begin
        if (cfg_rst) begin
            r_state       <= c_st_idle;
            r_cnt         <= '0;
            r_erase       <= 1'b0;
            r_col_mask    <= '0;
            r_cfgrows     <= '0;
            r_cfgcols     <= '0;
            r_col_err     <= 1'b0;
            r_col_written <= '0;
        end else begin
            r_col_err <= 1'b0;
            case (r_state)
                c_st_idle: begin
                    r_cfgrows <= '0;
                    r_cfgcols <= '0;
                    if (w_accept) begin
                        if (w_col_bad) begin
                            // Out-of-range column: drop the command, flag it.
                            r_col_err <= 1'b1;
                        end else begin
                            r_state    <= c_st_setup;
                            r_cnt      <= c_setup_last;
                            r_erase    <= in_erase;
                            r_col_mask <= in_erase ? '1 : w_col_oh;
                            r_cfgrows  <= in_erase ? '0 : in_rows;
                        end
                    end
                end
                c_st_setup: begin
                    if (r_cnt == '0) begin
                        r_state   <= c_st_pulse;
                        r_cnt     <= c_pulse_last;
                        r_cfgcols <= r_col_mask;
                    end else begin
                        r_cnt <= r_cnt - c_cnt_one;
                    end
                end
                c_st_pulse: begin
                    if (r_cnt == '0) begin
                        r_state   <= c_st_hold;
                        r_cnt     <= c_hold_last;
                        r_cfgcols <= '0;
                        r_col_written <= r_erase ? '0 : (r_col_written | r_col_mask);
                    end else begin
                        r_cnt <= r_cnt - c_cnt_one;
                    end
                end
                default: begin
                    if (r_cnt == '0) begin
                        r_state   <= c_st_idle;
                        r_cfgrows <= '0;
                    end else begin
                        r_cnt <= r_cnt - c_cnt_one;
                    end
                end
            endcase
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_nems_cfg_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : tb_nems_cfg_ctrl
// Description : Directed self-checking bench for nems_cfg_ctrl.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_nems_cfg_ctrl;

    localparam int NROWS = 30;
    localparam int NCOLS = 29;
    localparam int COLW  = 5;
    localparam int SEQ   = 4 + 16 + 4;

    logic             cfg_clk = 1'b0;
    logic             cfg_rst = 1'b1;
    logic             in_valid = 1'b0;
    logic             in_ready;
    logic             in_erase = 1'b0;
    logic [COLW-1:0]  in_col = '0;
    logic [NROWS-1:0] in_rows = '0;
    logic [NROWS-1:0] cfgrows;
    logic [NCOLS-1:0] cfgcols;
    logic             busy;
    logic             col_err;
    logic [NCOLS-1:0] col_written;
    logic             all_written;

    int               r_tests = 0;
    int               r_fails = 0;
    int               r_cycle = 0;
    int               r_last_accept = 0;
    logic [63:0]      r_exp_written = '0;

    nems_cfg_ctrl u_dut (
        .cfg_clk     (cfg_clk),
        .cfg_rst     (cfg_rst),
        .in_valid    (in_valid),
        .in_ready    (in_ready),
        .in_erase    (in_erase),
        .in_col      (in_col),
        .in_rows     (in_rows),
        .cfgrows     (cfgrows),
        .cfgcols     (cfgcols),
        .busy        (busy),
        .col_err     (col_err),
        .col_written (col_written),
        .all_written (all_written)
    );

    always #5 cfg_clk = ~cfg_clk;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        r_tests++;
        if (obs !== exp) begin
            r_fails++;
            $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", tag, obs, exp, r_cycle);
        end
    endtask

    // Advance one rising edge; inputs change and outputs are sampled 1ns after it.
    task automatic tick();
        @(posedge cfg_clk);
        #1;
        r_cycle++;
    endtask

    // Accept one command at the next edge and check every cycle of its sequence.
    task automatic run_seq(input logic erase, input int col, input logic [NROWS-1:0] rows,
                           input bit keep_valid, input bit toggle, input bit check_gap);
        logic [63:0] exp_rows;
        logic [63:0] exp_cols;
        logic [63:0] col_mask;
        in_valid = 1'b1;
        in_erase = erase;
        in_col   = COLW'(col);
        in_rows  = rows;
        tick();
        if (check_gap) check("accept_gap", 64'(r_cycle - r_last_accept), 64'(SEQ + 1));
        r_last_accept = r_cycle;
        if (!keep_valid) in_valid = 1'b0;
        col_mask = erase ? ((64'd1 << NCOLS) - 64'd1) : (64'd1 << col);
        for (int k = 1; k <= SEQ + 1; k++) begin
            if (k == 21) r_exp_written = erase ? 64'd0 : (r_exp_written | col_mask);
            exp_rows = (erase || k == SEQ + 1) ? 64'd0 : 64'(rows);
            exp_cols = (k >= 5 && k <= 20) ? col_mask : 64'd0;
            check("rows", 64'(cfgrows), exp_rows);
            check("cols", 64'(cfgcols), exp_cols);
            check("busy", 64'(busy), (k <= SEQ) ? 64'd1 : 64'd0);
            check("ready", 64'(in_ready), (k <= SEQ) ? 64'd0 : 64'd1);
            check("written", 64'(col_written), r_exp_written);
            check("all_wr", 64'(all_written), 64'(&r_exp_written[NCOLS-1:0]));
            if (toggle && k < SEQ) begin
                in_rows  = NROWS'($urandom);
                in_col   = COLW'($urandom);
                in_erase = 1'($urandom);
            end
            if (toggle && k == SEQ) in_erase = 1'b0;
            if (k <= SEQ) tick();
        end
    endtask

    initial begin
        // Reset state
        #2;
        check("rst_rows", 64'(cfgrows), 64'd0);
        check("rst_cols", 64'(cfgcols), 64'd0);
        check("rst_busy", 64'(busy), 64'd0);
        check("rst_err", 64'(col_err), 64'd0);
        check("rst_written", 64'(col_written), 64'd0);
        tick();
        cfg_rst = 1'b0;
        tick();
        check("rst_ready", 64'(in_ready), 64'd1);

        // Single write, column 3, rows 0x5
        run_seq(1'b0, 3, 30'h5, 1'b0, 1'b0, 1'b0);

        // Out-of-range write is dropped with a one-cycle error pulse
        in_valid = 1'b1;
        in_erase = 1'b0;
        in_col   = 5'd29;
        in_rows  = 30'h3FF;
        tick();
        in_valid = 1'b0;
        check("oor_err", 64'(col_err), 64'd1);
        check("oor_busy", 64'(busy), 64'd0);
        check("oor_ready", 64'(in_ready), 64'd1);
        check("oor_rows", 64'(cfgrows), 64'd0);
        check("oor_cols", 64'(cfgcols), 64'd0);
        tick();
        check("oor_err_clr", 64'(col_err), 64'd0);
        check("oor_busy2", 64'(busy), 64'd0);
        check("oor_written", 64'(col_written), r_exp_written);

        // Inputs toggled mid-sequence must not affect the latched command
        run_seq(1'b0, 10, 30'h2AAA_5555, 1'b0, 1'b1, 1'b0);
        in_valid = 1'b0;
        tick();

        // Asynchronous reset in the middle of a column pulse
        in_valid = 1'b1;
        in_erase = 1'b0;
        in_col   = 5'd7;
        in_rows  = 30'h1234;
        tick();
        in_valid = 1'b0;
        for (int i = 0; i < 10; i++) tick();
        check("mid_cols", 64'(cfgcols), 64'h80);
        check("mid_rows", 64'(cfgrows), 64'h1234);
        #2;
        cfg_rst = 1'b1;
        #1;
        check("arst_cols", 64'(cfgcols), 64'd0);
        check("arst_rows", 64'(cfgrows), 64'd0);
        check("arst_busy", 64'(busy), 64'd0);
        check("arst_written", 64'(col_written), 64'd0);
        r_exp_written = '0;
        tick();
        cfg_rst = 1'b0;
        tick();
        check("arst_ready", 64'(in_ready), 64'd1);
        check("arst_err", 64'(col_err), 64'd0);

        // Full load, back-to-back with in_valid held high
        for (int c = 0; c < NCOLS; c++) begin
            run_seq(1'b0, c, NROWS'(c + 1), 1'b1, 1'b0, c != 0);
        end
        in_valid = 1'b0;
        check("full_all", 64'(all_written), 64'd1);
        tick();

        // Global erase after the full load
        run_seq(1'b1, 0, 30'h3FFF_FFFF, 1'b0, 1'b0, 1'b0);
        tick();
        check("erase_all", 64'(all_written), 64'd0);

        $display("[TB] %0d tests run, %0d failed", r_tests, r_fails);
        $finish;
    end

    // Guard against a runaway simulation.
    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

endmodule
`default_nettype wire
